// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in-order packet queue between fetch and decode with sticky protocol-error flag
module fetch_queue #(
    parameter int DEPTH       = 8,
    parameter int PACKET_SIZE = 65,
    parameter int INSTR_COUNT = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [INSTR_COUNT-1:0]             enq_valid_i,
    input  logic [INSTR_COUNT*PACKET_SIZE-1:0] enq_data_i,
    output logic                               ready_o,
    output logic [INSTR_COUNT-1:0]             deq_valid_o,
    output logic [INSTR_COUNT*PACKET_SIZE-1:0] deq_data_o,
    input  logic [INSTR_COUNT-1:0]             deq_pop_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output logic                               err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [PACKET_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, n_enq, n_deq;
    logic err, enq_ok, enq_fire, enq_err, pop_ok, pop_err;
    always_comb begin
        ready_o     = count <= CW'(DEPTH - 2);
        deq_valid_o = {count >= CW'(2), count >= CW'(1)};
        deq_data_o  = {mem[head + PW'(1)], mem[head]};
        count_o     = count;
        err_o       = err;
        enq_ok      = enq_valid_i == 2'b01 || enq_valid_i == 2'b11;
        enq_fire    = !flush_i && ready_o && enq_ok;
        enq_err     = !flush_i && enq_valid_i != 2'b00 && !(ready_o && enq_ok);
        pop_ok      = (deq_pop_i == 2'b01 && deq_valid_o[0]) || (deq_pop_i == 2'b11 && deq_valid_o[1]);
        pop_err     = !flush_i && deq_pop_i != 2'b00 && !pop_ok;
        n_enq       = enq_fire ? (enq_valid_i[1] ? CW'(2) : CW'(1)) : CW'(0);
        n_deq       = (!flush_i && pop_ok) ? (deq_pop_i[1] ? CW'(2) : CW'(1)) : CW'(0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq);
            count <= count + n_enq - n_deq;
            if (enq_err || pop_err) err <= 1'b1;
        end
    end
    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst) begin
            mem[tail] <= enq_data_i[PACKET_SIZE-1:0];
            if (enq_valid_i[1]) mem[tail + PW'(1)] <= enq_data_i[2*PACKET_SIZE-1:PACKET_SIZE];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=8, 65-bit packets)
module tb_fetch_queue;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   enq_valid = 2'b00;
    logic [129:0] enq_data = '0;
    logic         ready;
    logic [1:0]   deq_valid;
    logic [129:0] deq_data;
    logic [1:0]   deq_pop = 2'b00;
    logic [3:0]   count;
    logic         err;
    logic [31:0]  pc0, pc1;
    int tests = 0;
    int fails = 0;

    fetch_queue #(.DEPTH(8), .PACKET_SIZE(65), .INSTR_COUNT(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .enq_valid_i(enq_valid), .enq_data_i(enq_data),
        .ready_o(ready), .deq_valid_o(deq_valid), .deq_data_o(deq_data), .deq_pop_i(deq_pop),
        .count_o(count), .err_o(err)
    );

    always #5 clk = ~clk;
    assign pc0 = deq_data[64:33];
    assign pc1 = deq_data[129:98];

    function automatic logic [64:0] pkt(input logic [31:0] pc);
        return {pc, ~pc, pc[2]};
    endfunction

    task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl);
        enq_valid = v;
        enq_data  = {pkt(p1), pkt(p0)};
        deq_pop   = pop;
        flush     = fl;
        @(posedge clk);
        #1;
        enq_valid = 2'b00;
        deq_pop   = 2'b00;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (deq_valid !== 2'b00) begin fails++; $display("FAIL reset_deq_valid got %b want 00", deq_valid); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(2'b11, 32'h100, 32'h104, 2'b00, 1'b0);
        tests++; if (deq_valid !== 2'b11) begin fails++; $display("FAIL basic_valid got %b want 11", deq_valid); end
        tests++; if (pc0 !== 32'h100) begin fails++; $display("FAIL basic_pc0 got %h want 100", pc0); end
        tests++; if (pc1 !== 32'h104) begin fails++; $display("FAIL basic_pc1 got %h want 104", pc1); end
        tests++; if (deq_data[64:0] !== pkt(32'h100)) begin fails++; $display("FAIL basic_pkt0 got %h want %h", deq_data[64:0], pkt(32'h100)); end
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL basic_count got %0d want 2", count); end
        cyc(2'b00, 0, 0, 2'b11, 1'b0);
        tests++; if (count !== 4'd0 || deq_valid !== 2'b00) begin fails++; $display("FAIL basic_drain count %0d valid %b want 0/00", count, deq_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(2'b11, 32'h200 + 8 * k, 32'h204 + 8 * k, 2'b00, 1'b0);
        tests++; if (count !== 4'd8 || ready !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL full_state count %0d ready %b err %b want 8/0/0", count, ready, err); end
        cyc(2'b11, 32'h900, 32'h904, 2'b00, 1'b0);
        tests++; if (count !== 4'd8 || err !== 1'b1) begin fails++; $display("FAIL full_drop count %0d err %b want 8/1", count, err); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (pc0 !== 32'h200 + 8 * k || pc1 !== 32'h204 + 8 * k) begin
                fails++; $display("FAIL full_order k=%0d got %h/%h want %h/%h", k, pc0, pc1, 32'h200 + 8 * k, 32'h204 + 8 * k);
            end
            cyc(2'b00, 0, 0, 2'b11, 1'b0);
        end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL full_drain count %0d want 0", count); end
    endtask

    task automatic test_count7();
        do_reset();
        for (int k = 0; k < 3; k++) cyc(2'b11, 32'h300 + 8 * k, 32'h304 + 8 * k, 2'b00, 1'b0);
        cyc(2'b01, 32'h318, 32'h0, 2'b00, 1'b0);
        tests++; if (count !== 4'd7 || ready !== 1'b0) begin fails++; $display("FAIL c7_ready count %0d ready %b want 7/0", count, ready); end
        cyc(2'b11, 32'h400, 32'h404, 2'b01, 1'b0);
        tests++; if (count !== 4'd6 || err !== 1'b1) begin fails++; $display("FAIL c7_result count %0d err %b want 6/1", count, err); end
        tests++; if (pc0 !== 32'h304) begin fails++; $display("FAIL c7_head got %h want 304", pc0); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                tests++;
                if (pc0 !== 32'h1000 + 8 * (i - 1) || pc1 !== 32'h1004 + 8 * (i - 1)) begin
                    fails++; $display("FAIL wrap_order i=%0d got %h/%h want %h/%h", i, pc0, pc1, 32'h1000 + 8 * (i - 1), 32'h1004 + 8 * (i - 1));
                end
            end
            cyc(i < 20 ? 2'b11 : 2'b00, 32'h1000 + 8 * i, 32'h1004 + 8 * i, i > 0 ? 2'b11 : 2'b00, 1'b0);
            tests++; if (count > 4'd2) begin fails++; $display("FAIL wrap_count i=%0d got %0d want <=2", i, count); end
        end
        tests++; if (count !== 4'd0 || err !== 1'b0) begin fails++; $display("FAIL wrap_end count %0d err %b want 0/0", count, err); end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(2'b00, 0, 0, 2'b10, 1'b1);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL flush_no_err got %b want 0", err); end
        cyc(2'b10, 0, 0, 2'b00, 1'b0);
        cyc(2'b11, 32'h600, 32'h604, 2'b00, 1'b0);
        cyc(2'b11, 32'h608, 32'h60c, 2'b00, 1'b0);
        cyc(2'b01, 32'h610, 32'h0, 2'b00, 1'b0);
        tests++; if (count !== 4'd5 || err !== 1'b1) begin fails++; $display("FAIL flush_pre count %0d err %b want 5/1", count, err); end
        cyc(2'b11, 32'h700, 32'h704, 2'b11, 1'b1);
        tests++; if (count !== 4'd0 || deq_valid !== 2'b00 || err !== 1'b1 || ready !== 1'b1) begin
            fails++; $display("FAIL flush_post count %0d valid %b err %b ready %b want 0/00/1/1", count, deq_valid, err, ready);
        end
        cyc(2'b01, 32'h720, 32'h0, 2'b00, 1'b0);
        tests++; if (pc0 !== 32'h720 || count !== 4'd1) begin fails++; $display("FAIL flush_restart pc %h count %0d want 720/1", pc0, count); end
    endtask

    task automatic test_pop10();
        do_reset();
        cyc(2'b11, 32'h800, 32'h804, 2'b00, 1'b0);
        cyc(2'b01, 32'h808, 32'h0, 2'b00, 1'b0);
        cyc(2'b00, 0, 0, 2'b10, 1'b0);
        tests++; if (count !== 4'd3 || err !== 1'b1 || pc0 !== 32'h800) begin fails++; $display("FAIL pop10 count %0d err %b pc %h want 3/1/800", count, err, pc0); end
        do_reset();
        tests++; if (count !== 4'd0 || err !== 1'b0 || deq_valid !== 2'b00) begin fails++; $display("FAIL pop10_rst count %0d err %b valid %b want 0/0/00", count, err, deq_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(2'b01, 32'h500, 32'h0, 2'b00, 1'b0);
        tests++; if (deq_valid !== 2'b01) begin fails++; $display("FAIL b2b_valid got %b want 01", deq_valid); end
        cyc(2'b00, 0, 0, 2'b11, 1'b0);
        tests++; if (count !== 4'd1 || err !== 1'b1) begin fails++; $display("FAIL b2b_overpop count %0d err %b want 1/1", count, err); end
        cyc(2'b11, 32'h510, 32'h514, 2'b01, 1'b0);
        tests++; if (count !== 4'd2 || pc0 !== 32'h510 || pc1 !== 32'h514) begin fails++; $display("FAIL b2b_simul count %0d pcs %h/%h want 2/510/514", count, pc0, pc1); end
        rst = 1'b1;
        cyc(2'b11, 32'h520, 32'h524, 2'b00, 1'b0);
        rst = 1'b0;
        tests++; if (count !== 4'd0 || err !== 1'b0) begin fails++; $display("FAIL b2b_rst_prio count %0d err %b want 0/0", count, err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_count7();
        test_wrap();
        test_flush();
        test_pop10();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; a power of 2, at least 4.
REQ-002 Parameter PACKET_SIZE, default 65, bits per fetched packet {pc[31:0], data[31:0], taken_branch}.
REQ-003 Parameter INSTR_COUNT, default 2, packets per enqueue/dequeue group; fixed at 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  discards all queued packets (restart/flush from back end).
REQ-007 enq_valid_i  input  2  per-slot valid of incoming fetch group; legal values 00, 01, 11.
REQ-008 enq_data_i  input  2*PACKET_SIZE  slot0 in bits [PACKET_SIZE-1:0], slot1 above it.
REQ-009 ready_o  output  1  queue can accept a full 2-packet group this cycle.
REQ-010 deq_valid_o  output  2  per-slot valid of the head group presented to decode.
REQ-011 deq_data_o  output  2*PACKET_SIZE  head packet in slot0, head+1 in slot1.
REQ-012 deq_pop_i  input  2  decode consumes slot0 (01) or both slots (11).
REQ-013 count_o  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 err_o  output  1  sticky protocol-error flag.

Function
REQ-015 Storage: circular buffer of DEPTH entries with head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy held in a separate counter.
REQ-016 ready_o = (DEPTH - count) >= 2, combinational from the registered count; no credit is given for same-cycle dequeue.
REQ-017 Enqueue fires when ready_o=1, flush_i=0, enq_valid_i is 01 or 11; slot0 is written at tail and slot1 (if valid) at tail+1; tail and count advance by 1 or 2.
REQ-018 enq_valid_i=10: no write, no pointer change, err_o set to 1 on the next edge.
REQ-019 enq_valid_i nonzero while ready_o=0: group dropped, no state change, err_o set.
REQ-020 deq_valid_o[0] = (count >= 1); deq_valid_o[1] = (count >= 2); deq_data_o is driven from head and head+1 regardless of valid.
REQ-021 Dequeue: pop 01 with deq_valid_o[0]=1 removes 1; pop 11 with deq_valid_o=11 removes 2; head advances and count decrements accordingly.
REQ-022 Pop 10, or a pop exceeding deq_valid_o: ignored entirely, err_o set.
REQ-023 Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq; both take effect on the same edge.
REQ-024 Latency: a packet enqueued at edge N is visible on deq_* after edge N; there is no combinational bypass from enq to deq.
REQ-025 Order: packets leave strictly in enqueue order, slot0 before slot1 within a group.
REQ-026 flush_i=1: on the next edge head=tail=0 and count=0; same-cycle enqueue and pop are discarded, and neither sets err_o.
REQ-027 err_o is cleared only by rst.

Reset
REQ-028 While rst=1 at a rising edge: head=0, tail=0, count=0, err_o=0; rst takes priority over flush, enqueue and pop.
REQ-029 After reset, outputs: ready_o=1, deq_valid_o=00, count_o=0, err_o=0; storage contents need not be reset.
REQ-030 Reset asserted mid-operation discards all entries exactly as in REQ-028; no partial group is retained.

Verification
REQ-031 Reset, then enqueue 11 with pcs 0x100/0x104 -> next cycle deq_valid_o=11, slot0 pc 0x100, slot1 pc 0x104, count_o=2.
REQ-032 Four 11 enqueues with no pops (DEPTH=8) -> count_o=8, ready_o=0; a fifth enqueue is dropped and sets err_o=1; the queue contents are unchanged.
REQ-033 count=7 with one pop 01 and one enqueue 11 in the same cycle -> ready_o=0 in that cycle, so the enqueue is dropped; count_o=6, err_o=1.
REQ-034 Wrap: 20 groups streamed with pop 11 every cycle -> output pc sequence is identical to the input pc sequence, count_o stays at or below 2, err_o=0.
REQ-035 count=5 with flush_i=1, enq 11 and pop 11 in the same cycle -> next cycle count_o=0, deq_valid_o=00, err_o unchanged.
REQ-036 Queue holding 3 entries with pop 10 -> no removal, count_o=3, err_o=1; then rst -> count_o=0, err_o=0.
